key_space_scheduler: RTL and testbench

- Distributes secret-key candidates from a shared key space across NUM_CORES parallel RC4 cracking cores (fill/shuffle/decrypt/check pipelines), one key per request.
- Tracks each core's in-flight key, stops all cores on the first successful decryption, and reports the winning key.
- Declares failure once every key has been tried without success.
- Sits above the per-core controllers and replaces the single key counter in a multi-core build.

---
 rtl/key_space_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_key_space_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_space_scheduler.sv
// key_space_scheduler
//
// Hands out secret-key candidates 0..KEY_MAX to NUM_CORES RC4 cracking cores, one key per
// request. Requests are served by round-robin. The block tracks the key each core is working
// on, stops everything on the first reported success, and declares failure once the whole key
// space has been checked without one.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   start       pulse; starts a search from key 0 (only in IDLE / DONE_OK / DONE_FAIL)
//   core_req    per-core level request for a new key
//   core_gnt    one-hot single-cycle grant, registered (one cycle after the request is sampled)
//   key_out     key that goes with core_gnt; zero outside grant cycles
//   core_done   per-core pulse: in-flight key finished
//   core_found  per-core, qualified by core_done: key decrypted correctly
//   abort       high in DONE_OK; cores drop their current work
//   busy        high in RUN or DRAIN
//   success     high in DONE_OK
//   fail        high in DONE_FAIL
//   found_key   winning key, valid while success is high
//   found_core  index of the winning core
module key_space_scheduler #(
    parameter int unsigned          NUM_CORES = 4,
    parameter int unsigned          KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_CORES-1:0]         core_req,
    output logic [NUM_CORES-1:0]         core_gnt,
    output logic [KEY_WIDTH-1:0]         key_out,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES-1:0]         core_found,
    output logic                         abort,
    output logic                         busy,
    output logic                         success,
    output logic                         fail,
    output logic [KEY_WIDTH-1:0]         found_key,
    output logic [$clog2(NUM_CORES)-1:0] found_core
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StDoneOk,
        StDoneFail
    } state_e;

    state_e                 state_q, state_d;
    // One bit wider than a key so it can sit at KEY_MAX+1 after the last grant.
    logic [KEY_WIDTH:0]     next_key_q, next_key_d;
    logic [NUM_CORES-1:0]   inflight_q, inflight_d;
    logic [KEY_WIDTH-1:0]   inflight_key_q [NUM_CORES];
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]   core_gnt_q, core_gnt_d;
    logic [KEY_WIDTH-1:0]   key_out_q, key_out_d;
    logic [KEY_WIDTH-1:0]   found_key_q, found_key_d;
    logic [IDX_W-1:0]       found_core_q, found_core_d;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   done_vec;
    logic [NUM_CORES-1:0]   found_vec;
    logic                   gnt_any;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   grant_fire;
    logic [IDX_W-1:0]       found_idx;

    assign eligible  = core_req & ~inflight_q;
    assign done_vec  = core_done & inflight_q;
    assign found_vec = done_vec & core_found;

    // Round-robin pick: first eligible core at or above rr_ptr, wrapping.
    always_comb begin
        logic [IDX_W-1:0] cand;
        int unsigned      idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        idx     = 0;
        for (int unsigned off = 0; off < NUM_CORES; off++) begin
            idx  = (32'(rr_ptr_q) + off) % NUM_CORES;
            cand = IDX_W'(idx);
            if (!gnt_any && eligible[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Lowest-index core wins when several report success together.
    always_comb begin
        found_idx = '0;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (found_vec[IDX_W'(i)]) begin
                found_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        next_key_d   = next_key_q;
        inflight_d   = inflight_q;
        rr_ptr_d     = rr_ptr_q;
        core_gnt_d   = '0;
        key_out_d    = '0;
        found_key_d  = found_key_q;
        found_core_d = found_core_q;
        grant_fire   = 1'b0;

        unique case (state_q)
            StIdle, StDoneOk, StDoneFail: begin
                if (start) begin
                    state_d      = StRun;
                    next_key_d   = '0;
                    inflight_d   = '0;
                    rr_ptr_d     = '0;
                    found_key_d  = '0;
                    found_core_d = '0;
                end
            end
            StRun, StDrain: begin
                inflight_d = inflight_q & ~done_vec;
                if (|found_vec) begin
                    // A success suppresses any grant in the same cycle.
                    state_d      = StDoneOk;
                    found_key_d  = inflight_key_q[found_idx];
                    found_core_d = found_idx;
                end else if (state_q == StRun) begin
                    if (gnt_any) begin
                        grant_fire             = 1'b1;
                        core_gnt_d             = NUM_CORES'(1) << gnt_idx;
                        key_out_d              = next_key_q[KEY_WIDTH-1:0];
                        inflight_d[gnt_idx]    = 1'b1;
                        next_key_d             = next_key_q + 1'b1;
                        rr_ptr_d               = (gnt_idx == IDX_W'(NUM_CORES - 1)) ?
                                                 '0 : gnt_idx + IDX_W'(1);
                        if (next_key_q == {1'b0, KEY_MAX}) begin
                            state_d = StDrain;
                        end
                    end
                end else if (inflight_d == '0) begin
                    state_d = StDoneFail;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            next_key_q   <= '0;
            inflight_q   <= '0;
            rr_ptr_q     <= '0;
            core_gnt_q   <= '0;
            key_out_q    <= '0;
            found_key_q  <= '0;
            found_core_q <= '0;
        end else begin
            state_q      <= state_d;
            next_key_q   <= next_key_d;
            inflight_q   <= inflight_d;
            rr_ptr_q     <= rr_ptr_d;
            core_gnt_q   <= core_gnt_d;
            key_out_q    <= key_out_d;
            found_key_q  <= found_key_d;
            found_core_q <= found_core_d;
        end
    end

    // Key storage is only read while the matching inflight bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            inflight_key_q[gnt_idx] <= next_key_q[KEY_WIDTH-1:0];
        end
    end

    assign core_gnt   = core_gnt_q;
    assign key_out    = key_out_q;
    assign found_key  = found_key_q;
    assign found_core = found_core_q;
    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign success    = (state_q == StDoneOk);
    assign abort      = (state_q == StDoneOk);
    assign fail       = (state_q == StDoneFail);

endmodule

// File: tb/tb_key_space_scheduler.sv
// Bench for key_space_scheduler with NUM_CORES=4, KEY_MAX=7. Expected grants are queued as
// requests are driven and compared when core_gnt pulses; flags are checked after each step.
module tb_key_space_scheduler;

    localparam int unsigned NC = 4;
    localparam int unsigned KW = 24;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NC-1:0] core_req;
    logic [NC-1:0] core_gnt;
    logic [KW-1:0] key_out;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_found;
    logic          abort;
    logic          busy;
    logic          success;
    logic          fail;
    logic [KW-1:0] found_key;
    logic [1:0]    found_core;

    key_space_scheduler #(
        .NUM_CORES (NC),
        .KEY_WIDTH (KW),
        .KEY_MAX   (24'd7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .core_req   (core_req),
        .core_gnt   (core_gnt),
        .key_out    (key_out),
        .core_done  (core_done),
        .core_found (core_found),
        .abort      (abort),
        .busy       (busy),
        .success    (success),
        .fail       (fail),
        .found_key  (found_key),
        .found_core (found_core)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC-1:0] gnt;
        logic [KW-1:0] key;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_gnt(input int core, input int key);
        exp_t e;
        e.gnt = NC'(1) << core;
        e.key = KW'(key);
        exp_q.push_back(e);
    endtask

    // One clock: sample grants just after the edge, emulate cores dropping req on grant,
    // and clear single-cycle pulses.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (core_gnt != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("gnt_unexpected", 32'(core_gnt), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("gnt_core", 32'(core_gnt), 32'(e.gnt));
                check_eq("gnt_key", 32'(key_out), 32'(e.key));
            end
        end
        core_req   = core_req & ~core_gnt;
        core_done  = '0;
        core_found = '0;
        start      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_queue_empty(input string tag);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        core_req   = '0;
        core_done  = '0;
        core_found = '0;
        ticks(2);
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst_gnt", 32'(core_gnt), 32'd0);
        check_eq("rst_key", 32'(key_out), 32'd0);
        check_eq("rst_abort", 32'(abort), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_success", 32'(success), 32'd0);
        check_eq("rst_fail", 32'(fail), 32'd0);
        check_eq("rst_found_key", 32'(found_key), 32'd0);
        check_eq("rst_found_core", 32'(found_core), 32'd0);

        // ---- Run A: dispatch, round-robin refill, done+grant together, exhaustion
        do_start();
        check_eq("a_busy_start", 32'(busy), 32'd1);
        core_req = 4'b1111;
        expect_gnt(0, 0); expect_gnt(1, 1); expect_gnt(2, 2); expect_gnt(3, 3);
        ticks(4);
        check_eq("a_busy_run", 32'(busy), 32'd1);
        check_queue_empty("a_dispatch_done");
        tick();
        check_eq("a_idle_gnt", 32'(core_gnt), 32'd0);

        core_done = 4'b0101;
        tick();
        core_req = 4'b0101;
        expect_gnt(0, 4); expect_gnt(2, 5);
        ticks(2);
        check_queue_empty("a_refill_done");

        core_done = 4'b1000;
        tick();
        core_done = 4'b0010;
        core_req  = 4'b1000;
        expect_gnt(3, 6);
        tick();
        check_queue_empty("a_done_and_gnt");

        // Core 1 was freed in the previous cycle; it receives the last key.
        core_req = 4'b0010;
        expect_gnt(1, 7);
        tick();
        check_queue_empty("a_last_key");
        check_eq("a_busy_drain", 32'(busy), 32'd1);
        check_eq("a_fail_drain", 32'(fail), 32'd0);

        core_done = 4'b0001;
        tick();
        core_req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("a_drain_nognt", 32'(core_gnt), 32'd0);
        end
        core_req = '0;
        core_done = 4'b0100;
        tick();
        core_done = 4'b1000;
        tick();
        check_eq("a_fail_pending", 32'(fail), 32'd0);
        check_eq("a_busy_pending", 32'(busy), 32'd1);
        core_done = 4'b0010;
        tick();
        check_eq("a_fail", 32'(fail), 32'd1);
        check_eq("a_success", 32'(success), 32'd0);
        check_eq("a_busy_end", 32'(busy), 32'd0);
        check_eq("a_abort", 32'(abort), 32'd0);
        tick();
        check_eq("a_fail_held", 32'(fail), 32'd1);

        // ---- Run B: success on core 1 holding key 5
        do_start();
        check_eq("b_fail_cleared", 32'(fail), 32'd0);
        check_eq("b_busy", 32'(busy), 32'd1);
        core_req = 4'b1111;
        expect_gnt(0, 0); expect_gnt(1, 1); expect_gnt(2, 2); expect_gnt(3, 3);
        ticks(4);
        core_done = 4'b0011;
        tick();
        core_req = 4'b0011;
        expect_gnt(0, 4); expect_gnt(1, 5);
        ticks(2);
        core_done = 4'b0100;
        tick();
        check_queue_empty("b_setup");

        // Found on core 1 while core 2 is eligible: the found wins, no grant.
        core_req   = 4'b0100;
        core_done  = 4'b0010;
        core_found = 4'b0010;
        tick();
        check_eq("b_nognt_found", 32'(core_gnt), 32'd0);
        check_eq("b_success", 32'(success), 32'd1);
        check_eq("b_abort", 32'(abort), 32'd1);
        check_eq("b_found_key", 32'(found_key), 32'd5);
        check_eq("b_found_core", 32'(found_core), 32'd1);
        check_eq("b_busy", 32'(busy), 32'd0);
        core_done  = 4'b1000;
        core_found = 4'b1000;
        tick();
        ticks(2);
        check_eq("b_late_key", 32'(found_key), 32'd5);
        check_eq("b_late_core", 32'(found_core), 32'd1);
        check_eq("b_success_held", 32'(success), 32'd1);
        check_queue_empty("b_no_more_gnt");

        // ---- Run C: simultaneous found on cores 3 and 1
        core_req = '0;
        do_start();
        check_eq("c_found_key_clr", 32'(found_key), 32'd0);
        check_eq("c_success_clr", 32'(success), 32'd0);
        core_req = 4'b1111;
        expect_gnt(0, 0); expect_gnt(1, 1); expect_gnt(2, 2); expect_gnt(3, 3);
        ticks(4);
        core_done  = 4'b1010;
        core_found = 4'b1010;
        tick();
        check_eq("c_found_core", 32'(found_core), 32'd1);
        check_eq("c_found_key", 32'(found_key), 32'd1);
        check_eq("c_success", 32'(success), 32'd1);
        check_queue_empty("c_end");

        // ---- Run D: start ignored in RUN, reset mid-search
        do_start();
        core_req = 4'b0011;
        expect_gnt(0, 0); expect_gnt(1, 1);
        ticks(2);
        start = 1'b1;
        tick();
        core_req = 4'b0100;
        expect_gnt(2, 2);
        tick();
        check_queue_empty("d_start_ignored");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("d_rst_busy", 32'(busy), 32'd0);
        check_eq("d_rst_gnt", 32'(core_gnt), 32'd0);
        check_eq("d_rst_flags", 32'({abort, success, fail}), 32'd0);
        check_eq("d_rst_found", 32'(found_key), 32'd0);
        tick();
        do_start();
        core_req = 4'b0001;
        expect_gnt(0, 0);
        tick();
        check_queue_empty("d_restart");
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
